// File: rtl/bist_response_checker_pkg.sv
// Shared types and constants for the BIST response checker: FSM state encoding,
// default datapath width and the width of the accepted-result counter.
package bist_response_checker_pkg;

  localparam int DEF_WIDTH = 24;
  localparam int COUNT_W   = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_COMPARE = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

endpackage

// File: rtl/bist_response_checker_if.sv
// Valid/ready result stream from the unit under test into the response checker.
interface bist_response_checker_if
  import bist_response_checker_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic             res_valid;
  logic [WIDTH-1:0] res_data;
  logic             res_ready;

  modport master (
    output res_valid,
    output res_data,
    input  res_ready
  );

  modport slave (
    input  res_valid,
    input  res_data,
    output res_ready
  );

endinterface

// File: rtl/bist_response_checker_misr.sv
// Serial-shift multiple-input signature register: shifts left with the MSB
// feedback folded into bit 0, then XORs in the incoming result word.
module bist_response_checker_misr
  import bist_response_checker_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] sig_o
);

  logic [WIDTH-1:0] misr_q;
  logic             fb;

  assign fb = misr_q[WIDTH-1] ^ data_i[WIDTH-1];

  // Clear outranks compaction so a new run always starts from a zero signature
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      misr_q <= '0;
    end else if (clr_i) begin
      misr_q <= '0;
    end else if (en_i) begin
      misr_q <= {misr_q[WIDTH-2:0], fb} ^ data_i;
    end
  end

  assign sig_o = misr_q;

endmodule

// File: rtl/bist_response_checker.sv
// BIST response evaluator: compacts a result stream into a MISR signature and,
// after NUM_VECTORS results, latches a PASS/FAIL verdict against golden_i.
module bist_response_checker
  import bist_response_checker_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int NUM_VECTORS = 256,
  parameter int TIMEOUT     = 1024
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic [WIDTH-1:0]      golden_i,
  bist_response_checker_if.slave res,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  pass_o,
  output logic                  timeout_o,
  output logic [COUNT_W-1:0]    count_o,
  output logic [WIDTH-1:0]      signature_o
);

  localparam int IDLE_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [COUNT_W:0]  LAST_IDX  = (COUNT_W + 1)'(NUM_VECTORS - 1);
  localparam logic [IDLE_W-1:0] IDLE_LIM  = IDLE_W'(TIMEOUT - 1);

  // Count holds at all-ones so NUM_VECTORS == 2**16 cannot wrap back to zero
  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
    return (&v) ? v : v + COUNT_W'(1);
  endfunction

  state_e            state_q, state_d;
  logic [COUNT_W-1:0] count_q;
  logic [IDLE_W-1:0]  idle_q;
  logic               done_q, pass_q, timeout_q;
  logic               xfer, last_xfer, idle_expire;
  logic               start_run, fin_abort, fin_timeout, fin_compare;
  logic [WIDTH-1:0]   sig;

  assign res.res_ready = (state_q == ST_RUN);
  assign busy_o        = (state_q == ST_RUN) || (state_q == ST_COMPARE);

  // abort_i suppresses the transfer it coincides with
  assign xfer        = res.res_valid && (state_q == ST_RUN) && !abort_i;
  assign last_xfer   = xfer && ({1'b0, count_q} == LAST_IDX);
  assign idle_expire = (state_q == ST_RUN) && !res.res_valid && !abort_i && (idle_q == IDLE_LIM);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    start_run   = 1'b0;
    fin_abort   = 1'b0;
    fin_timeout = 1'b0;
    fin_compare = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d   = ST_RUN;
          start_run = 1'b1;
        end
      end
      ST_RUN: begin
        if (abort_i) begin
          state_d   = ST_DONE;
          fin_abort = 1'b1;
        end else if (last_xfer) begin
          state_d = ST_COMPARE;
        end else if (idle_expire) begin
          state_d     = ST_DONE;
          fin_timeout = 1'b1;
        end
      end
      ST_COMPARE: begin
        state_d = ST_DONE;
        if (abort_i) fin_abort   = 1'b1;
        else         fin_compare = 1'b1;
      end
      ST_DONE: begin
        if (start_i) begin
          state_d   = ST_RUN;
          start_run = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Run counters: accepted results and consecutive idle cycles
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      count_q <= '0;
      idle_q  <= '0;
    end else begin
      if (start_run)  count_q <= '0;
      else if (xfer)  count_q <= sat_inc(count_q);

      if (start_run || xfer)       idle_q <= '0;
      else if (state_q == ST_RUN)  idle_q <= idle_q + IDLE_W'(1);
    end
  end

  // Verdict registers hold through DONE until the next start
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else if (start_run) begin
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else if (fin_compare) begin
      done_q    <= 1'b1;
      pass_q    <= (sig == golden_i);
      timeout_q <= 1'b0;
    end else if (fin_timeout) begin
      done_q    <= 1'b1;
      pass_q    <= 1'b0;
      timeout_q <= 1'b1;
    end else if (fin_abort) begin
      done_q    <= 1'b1;
      pass_q    <= 1'b0;
      timeout_q <= 1'b0;
    end
  end

  bist_response_checker_misr #(
    .WIDTH (WIDTH)
  ) u_misr (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .en_i   (xfer),
    .clr_i  (start_run),
    .data_i (res.res_data),
    .sig_o  (sig)
  );

  assign done_o      = done_q;
  assign pass_o      = pass_q;
  assign timeout_o   = timeout_q;
  assign count_o     = count_q;
  assign signature_o = sig;

endmodule

// File: tb/tb_bist_response_checker.sv
// Directed bench for bist_response_checker: three instances with NUM_VECTORS
// of 1, 2 and 4 exercise verdicts, gaps, timeout, abort and reset.
module tb_bist_response_checker;

  localparam int W = 24;

  logic clk;
  logic rst_n;

  logic          start_1, abort_1, busy_1, done_1, pass_1, tmo_1;
  logic [W-1:0]  golden_1, sig_1;
  logic [15:0]   count_1;
  logic          start_2, abort_2, busy_2, done_2, pass_2, tmo_2;
  logic [W-1:0]  golden_2, sig_2;
  logic [15:0]   count_2;
  logic          start_4, abort_4, busy_4, done_4, pass_4, tmo_4;
  logic [W-1:0]  golden_4, sig_4;
  logic [15:0]   count_4;

  int n_assert = 0;
  int n_fail   = 0;

  bist_response_checker_if #(.WIDTH(W)) bus_1 ();
  bist_response_checker_if #(.WIDTH(W)) bus_2 ();
  bist_response_checker_if #(.WIDTH(W)) bus_4 ();

  bist_response_checker #(.WIDTH(W), .NUM_VECTORS(1), .TIMEOUT(1024)) u1 (
    .clk_i(clk), .rst_i(rst_n), .start_i(start_1), .abort_i(abort_1), .golden_i(golden_1),
    .res(bus_1), .busy_o(busy_1), .done_o(done_1), .pass_o(pass_1), .timeout_o(tmo_1),
    .count_o(count_1), .signature_o(sig_1));

  bist_response_checker #(.WIDTH(W), .NUM_VECTORS(2), .TIMEOUT(1024)) u2 (
    .clk_i(clk), .rst_i(rst_n), .start_i(start_2), .abort_i(abort_2), .golden_i(golden_2),
    .res(bus_2), .busy_o(busy_2), .done_o(done_2), .pass_o(pass_2), .timeout_o(tmo_2),
    .count_o(count_2), .signature_o(sig_2));

  bist_response_checker #(.WIDTH(W), .NUM_VECTORS(4), .TIMEOUT(16)) u4 (
    .clk_i(clk), .rst_i(rst_n), .start_i(start_4), .abort_i(abort_4), .golden_i(golden_4),
    .res(bus_4), .busy_o(busy_4), .done_o(done_4), .pass_o(pass_4), .timeout_o(tmo_4),
    .count_o(count_4), .signature_o(sig_4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start_1 = 0; abort_1 = 0; golden_1 = '0;
    start_2 = 0; abort_2 = 0; golden_2 = '0;
    start_4 = 0; abort_4 = 0; golden_4 = '0;
    bus_1.res_valid = 0; bus_1.res_data = '0;
    bus_2.res_valid = 0; bus_2.res_data = '0;
    bus_4.res_valid = 0; bus_4.res_data = '0;
    tick(2);

    // Reset state
    check("rst_busy",  32'(busy_1),  32'h0);
    check("rst_done",  32'(done_1),  32'h0);
    check("rst_pass",  32'(pass_1),  32'h0);
    check("rst_tmo",   32'(tmo_1),   32'h0);
    check("rst_count", 32'(count_1), 32'h0);
    check("rst_sig",   32'(sig_1),   32'h0);
    check("rst_ready", 32'(bus_1.res_ready), 32'h0);
    rst_n = 1'b1;
    tick();

    // valid in IDLE is ignored
    bus_2.res_valid = 1; bus_2.res_data = 24'hFFFFFF;
    tick(2);
    bus_2.res_valid = 0;
    check("idle_count", 32'(count_2), 32'h0);
    check("idle_sig",   32'(sig_2),   32'h0);

    // NUM_VECTORS=1: single word, verdict two clocks after it is presented
    start_1 = 1; tick(); start_1 = 0;
    check("n1_ready", 32'(bus_1.res_ready), 32'h1);
    check("n1_busy",  32'(busy_1), 32'h1);
    golden_1 = 24'h000001;
    bus_1.res_valid = 1; bus_1.res_data = 24'h000001;
    tick();
    bus_1.res_valid = 0;
    check("n1_sig",        32'(sig_1),   32'h000001);
    check("n1_count",      32'(count_1), 32'h1);
    check("n1_done_early", 32'(done_1),  32'h0);
    check("n1_ready_cmp",  32'(bus_1.res_ready), 32'h0);
    tick();
    check("n1_done", 32'(done_1), 32'h1);
    check("n1_pass", 32'(pass_1), 32'h1);
    check("n1_tmo",  32'(tmo_1),  32'h0);
    check("n1_busy_done", 32'(busy_1), 32'h0);

    // NUM_VECTORS=2, gap-free, matching golden
    start_2 = 1; tick(); start_2 = 0;
    golden_2 = 24'h000003;
    bus_2.res_valid = 1; bus_2.res_data = 24'h800000;
    tick();
    check("n2_sig1", 32'(sig_2), 32'h800001);
    bus_2.res_data = 24'h000000;
    tick();
    bus_2.res_valid = 0;
    check("n2_sig2",  32'(sig_2),   32'h000003);
    check("n2_count", 32'(count_2), 32'h2);
    tick();
    check("n2_done", 32'(done_2), 32'h1);
    check("n2_pass", 32'(pass_2), 32'h1);

    // Same stream, gapped, start_i pulsed mid-run, wrong golden
    start_2 = 1; tick(); start_2 = 0;
    check("n2b_done_clr", 32'(done_2),  32'h0);
    check("n2b_pass_clr", 32'(pass_2),  32'h0);
    check("n2b_count0",   32'(count_2), 32'h0);
    golden_2 = 24'h000004;
    bus_2.res_valid = 1; bus_2.res_data = 24'h800000;
    tick();
    bus_2.res_valid = 0; start_2 = 1;
    tick();
    start_2 = 0;
    check("n2b_gap_count", 32'(count_2), 32'h1);
    check("n2b_gap_sig",   32'(sig_2),   32'h800001);
    check("n2b_gap_busy",  32'(busy_2),  32'h1);
    bus_2.res_valid = 1; bus_2.res_data = 24'h000000;
    tick();
    bus_2.res_valid = 0;
    check("n2b_sig", 32'(sig_2), 32'h000003);
    tick();
    check("n2b_done", 32'(done_2), 32'h1);
    check("n2b_pass", 32'(pass_2), 32'h0);
    check("n2b_tmo",  32'(tmo_2),  32'h0);

    // valid in DONE is ignored
    bus_2.res_valid = 1; bus_2.res_data = 24'hFFFFFF;
    tick(2);
    bus_2.res_valid = 0;
    check("done_hold_count", 32'(count_2), 32'h2);
    check("done_hold_sig",   32'(sig_2),   32'h000003);
    check("done_hold_done",  32'(done_2),  32'h1);

    // NUM_VECTORS=4, TIMEOUT=16: two words then silence
    start_4 = 1; tick(); start_4 = 0;
    bus_4.res_valid = 1; bus_4.res_data = 24'h000001;
    tick();
    bus_4.res_data = 24'h000005;
    tick();
    bus_4.res_valid = 0;
    check("to_sig", 32'(sig_4), 32'h000007);
    tick(15);
    check("to_not_yet", 32'(done_4), 32'h0);
    check("to_busy",    32'(busy_4), 32'h1);
    tick();
    check("to_done",  32'(done_4),  32'h1);
    check("to_tmo",   32'(tmo_4),   32'h1);
    check("to_pass",  32'(pass_4),  32'h0);
    check("to_count", 32'(count_4), 32'h2);

    // abort concurrent with a transfer
    start_4 = 1; tick(); start_4 = 0;
    check("ab_tmo_clr", 32'(tmo_4), 32'h0);
    bus_4.res_valid = 1; bus_4.res_data = 24'h00000A;
    tick();
    bus_4.res_data = 24'h000055; abort_4 = 1;
    tick();
    abort_4 = 0; bus_4.res_valid = 0;
    check("ab_done",  32'(done_4),  32'h1);
    check("ab_pass",  32'(pass_4),  32'h0);
    check("ab_tmo",   32'(tmo_4),   32'h0);
    check("ab_count", 32'(count_4), 32'h1);
    check("ab_sig",   32'(sig_4),   32'h00000A);

    // abort in DONE does nothing; start beats abort in DONE
    abort_4 = 1; tick();
    check("ab_done_hold", 32'(done_4), 32'h1);
    check("ab_busy_hold", 32'(busy_4), 32'h0);
    start_4 = 1; tick(); start_4 = 0; abort_4 = 0;
    check("sa_busy",  32'(busy_4),  32'h1);
    check("sa_done",  32'(done_4),  32'h0);
    check("sa_count", 32'(count_4), 32'h0);

    // reset mid-run
    bus_4.res_valid = 1; bus_4.res_data = 24'h000003;
    tick();
    bus_4.res_valid = 0;
    check("mr_count_pre", 32'(count_4), 32'h1);
    rst_n = 1'b0;
    #1;
    check("mr_busy",  32'(busy_4),  32'h0);
    check("mr_done",  32'(done_4),  32'h0);
    check("mr_count", 32'(count_4), 32'h0);
    check("mr_sig",   32'(sig_4),   32'h0);
    check("mr_ready", 32'(bus_4.res_ready), 32'h0);
    check("mr_done2", 32'(done_2),  32'h0);
    check("mr_pass1", 32'(pass_1),  32'h0);
    rst_n = 1'b1;
    tick(2);
    check("mr_idle", 32'(busy_4), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
